// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect types: B payload layout, response codes, router index helper.
// No logic; widths default to the interconnect-wide configuration below.
// No flow control.
`ifndef AXI_CONFIG_SVH
`define AXI_CONFIG_SVH
`define ID_W_WIDTH  8
`define BRESP_WIDTH 2
`endif

package axi_ic_pkg;

    localparam int ID_W_WIDTH  = `ID_W_WIDTH;
    localparam int BRESP_WIDTH = `BRESP_WIDTH;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [BRESP_WIDTH-1:0] bresp;
        logic [ID_W_WIDTH-1:0]  bid;
    } b_payload_t;

    // The router steers B back to the master encoded in the upper half of bid.
    function automatic logic [ID_W_WIDTH/2-1:0] b_master_idx(input logic [ID_W_WIDTH-1:0] bid);
        return bid[ID_W_WIDTH-1 -: ID_W_WIDTH/2];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO with registered full/empty and occupancy count.
// Latency: a pushed word is visible on pop_dat_o the following cycle; no bypass.
// Backpressure: push ignored while full_o, pop ignored while empty_o.
module sync_fifo #(
    parameter int DataWidth = 8,
    parameter int Depth     = 4,
    localparam int PtrW     = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int CntW     = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] push_dat_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] pop_dat_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CntW-1:0]      count_o
);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 push_ok, pop_ok;

    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i & ~empty_q;

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CntW'(Depth));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign count_o   = count_q;

endmodule

// File: rtl/axi_ic_b_slave_buffer.sv
// Per-slave B response buffer: queues {bid,bresp}, counts outstanding writes, stalls AW at the limit.
// Latency: one cycle slave B to router B; no same-cycle bypass.
// Backpressure: s_bready_o drops when the FIFO is full; aw_stall_o asserts at MaxOutstanding.
module axi_ic_b_slave_buffer
    import axi_ic_pkg::*;
#(
    parameter int IdWidth        = ID_W_WIDTH,
    parameter int RespWidth      = BRESP_WIDTH,
    parameter int Depth          = 4,
    parameter int MaxOutstanding = 6,
    localparam int OutW          = $clog2(MaxOutstanding + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 aw_hs_i,
    output logic                 aw_stall_o,
    input  logic                 s_bvalid_i,
    output logic                 s_bready_o,
    input  logic [IdWidth-1:0]   s_bid_i,
    input  logic [RespWidth-1:0] s_bresp_i,
    output logic                 m_bvalid_o,
    input  logic                 m_bready_i,
    output logic [IdWidth-1:0]   m_bid_o,
    output logic [RespWidth-1:0] m_bresp_o,
    output logic [OutW-1:0]      outstanding_o,
    output logic                 unexp_b_o
);

    localparam int DataWidth = IdWidth + RespWidth;
    localparam int CntW      = $clog2(Depth + 1);

    logic                 fifo_full, fifo_empty;
    logic [CntW-1:0]      fifo_count;
    logic [DataWidth-1:0] fifo_rd_dat;
    logic                 push, pop;
    logic                 at_max, at_zero;
    logic                 no_pending;
    logic [OutW-1:0]      out_q, out_d;
    logic                 unexp_q, unexp_d;

    assign s_bready_o = ~fifo_full & ~rst_i;
    assign m_bvalid_o = ~fifo_empty & ~rst_i;
    assign push       = s_bvalid_i & s_bready_o;
    assign pop        = m_bvalid_o & m_bready_i;

    sync_fifo #(
        .DataWidth(DataWidth),
        .Depth    (Depth)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (push),
        .push_dat_i({s_bresp_i, s_bid_i}),
        .pop_i     (pop),
        .pop_dat_o (fifo_rd_dat),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign {m_bresp_o, m_bid_o} = fifo_rd_dat;

    assign at_max  = (out_q == OutW'(MaxOutstanding));
    assign at_zero = (out_q == '0);

    // After an unexpected B the FIFO can hold more than is outstanding, so
    // "nothing pending at the slave" is outstanding <= buffered, not just equality.
    assign no_pending = (out_q <= OutW'(fifo_count));

    always_comb begin
        out_d = out_q;
        if (aw_hs_i && !pop && !at_max) begin
            out_d = out_q + 1'b1;
        end else if (pop && !aw_hs_i && !at_zero) begin
            out_d = out_q - 1'b1;
        end
        unexp_d = unexp_q | (push & no_pending);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q   <= '0;
            unexp_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            unexp_q <= unexp_d;
        end
    end

    assign aw_stall_o    = at_max & ~rst_i;
    assign outstanding_o = out_q;
    assign unexp_b_o     = unexp_q;

endmodule

// File: tb/tb_axi_ic_b_slave_buffer.sv
// Self-checking bench for axi_ic_b_slave_buffer: vector table, directed corner sequences, random run.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge against a queue-based model.
// Backpressure exercised via m_bready and FIFO-full / outstanding-limit scenarios.
module tb_axi_ic_b_slave_buffer;
    import axi_ic_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXO  = 6;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       aw_hs_i;
    logic       aw_stall_o;
    logic       s_bvalid_i;
    logic       s_bready_o;
    logic [7:0] s_bid_i;
    logic [1:0] s_bresp_i;
    logic       m_bvalid_o;
    logic       m_bready_i;
    logic [7:0] m_bid_o;
    logic [1:0] m_bresp_o;
    logic [2:0] outstanding_o;
    logic       unexp_b_o;

    always #5 clk = ~clk;

    axi_ic_b_slave_buffer #(
        .IdWidth(8), .RespWidth(2), .Depth(DEPTH), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .aw_hs_i(aw_hs_i), .aw_stall_o(aw_stall_o),
        .s_bvalid_i(s_bvalid_i), .s_bready_o(s_bready_o), .s_bid_i(s_bid_i), .s_bresp_i(s_bresp_i),
        .m_bvalid_o(m_bvalid_o), .m_bready_i(m_bready_i), .m_bid_o(m_bid_o), .m_bresp_o(m_bresp_o),
        .outstanding_o(outstanding_o), .unexp_b_o(unexp_b_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: buffered responses as a queue, outstanding as a plain integer.
    logic [9:0] mq[$];
    int         m_out   = 0;
    bit         m_unexp = 1'b0;
    logic [9:0] got_q[$];

    typedef struct {
        bit       aw;
        bit       sv;
        bit [7:0] bid;
        bit [1:0] bresp;
        bit       mr;
        bit       e_bready;
        bit       e_bvalid;
        bit [7:0] e_bid;
        bit [1:0] e_bresp;
        int       e_out;
        bit       e_unexp;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("s_bready", 32'(s_bready_o), 32'(!rst_i && mq.size() < DEPTH));
        chk("m_bvalid", 32'(m_bvalid_o), 32'(!rst_i && mq.size() > 0));
        if (!rst_i && mq.size() > 0)
            chk("m_payload", 32'({m_bresp_o, m_bid_o}), 32'(mq[0]));
        chk("outstanding", 32'(outstanding_o), 32'(m_out));
        chk("aw_stall", 32'(aw_stall_o), 32'(!rst_i && m_out == MAXO));
        chk("unexp_b", 32'(unexp_b_o), 32'(m_unexp));
    endtask

    task automatic model_step();
        bit push, pop;
        push = s_bvalid_i && !rst_i && (mq.size() < DEPTH);
        pop  = m_bready_i && !rst_i && (mq.size() > 0);
        if (rst_i) begin
            mq.delete();
            m_out   = 0;
            m_unexp = 1'b0;
        end else begin
            if (push && (m_out - mq.size()) <= 0) m_unexp = 1'b1;
            if (aw_hs_i && !pop)      m_out = (m_out == MAXO) ? MAXO : m_out + 1;
            else if (pop && !aw_hs_i) m_out = (m_out == 0) ? 0 : m_out - 1;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back({s_bresp_i, s_bid_i});
        end
    endtask

    task automatic neg();
        @(negedge clk);
        check_model();
        if (m_bvalid_o && m_bready_i && !rst_i) got_q.push_back({m_bresp_o, m_bid_o});
    endtask

    task automatic fin();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        neg();
        fin();
    endtask

    task automatic idle_inputs();
        aw_hs_i = 1'b0; s_bvalid_i = 1'b0; s_bid_i = '0; s_bresp_i = '0; m_bready_i = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        repeat (n) cycle();
        rst_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1, 0, 8'h00, AXI_RESP_OKAY,   1, 1, 0, 8'h00, AXI_RESP_OKAY,   0, 0};
        tbl[1]  = '{1, 0, 8'h00, AXI_RESP_OKAY,   1, 1, 0, 8'h00, AXI_RESP_OKAY,   1, 0};
        tbl[2]  = '{1, 0, 8'h00, AXI_RESP_OKAY,   1, 1, 0, 8'h00, AXI_RESP_OKAY,   2, 0};
        tbl[3]  = '{0, 1, 8'h12, AXI_RESP_OKAY,   1, 1, 0, 8'h00, AXI_RESP_OKAY,   3, 0};
        tbl[4]  = '{0, 1, 8'h34, AXI_RESP_SLVERR, 1, 1, 1, 8'h12, AXI_RESP_OKAY,   3, 0};
        tbl[5]  = '{0, 1, 8'h56, AXI_RESP_OKAY,   1, 1, 1, 8'h34, AXI_RESP_SLVERR, 2, 0};
        tbl[6]  = '{0, 0, 8'h00, AXI_RESP_OKAY,   1, 1, 1, 8'h56, AXI_RESP_OKAY,   1, 0};
        tbl[7]  = '{0, 0, 8'h00, AXI_RESP_OKAY,   1, 1, 0, 8'h00, AXI_RESP_OKAY,   0, 0};
        tbl[8]  = '{0, 1, 8'h7F, AXI_RESP_DECERR, 1, 1, 0, 8'h00, AXI_RESP_OKAY,   0, 0};
        tbl[9]  = '{0, 0, 8'h00, AXI_RESP_OKAY,   1, 1, 1, 8'h7F, AXI_RESP_DECERR, 0, 1};
        tbl[10] = '{0, 0, 8'h00, AXI_RESP_OKAY,   1, 1, 0, 8'h00, AXI_RESP_OKAY,   0, 1};

        // Reset behaviour
        idle_inputs();
        rst_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            neg();
            chk("rst_s_bready", 32'(s_bready_o), 32'd0);
            chk("rst_m_bvalid", 32'(m_bvalid_o), 32'd0);
            fin();
        end
        rst_i = 1'b0;
        neg();
        chk("post_rst_s_bready", 32'(s_bready_o), 32'd1);
        chk("post_rst_outstanding", 32'(outstanding_o), 32'd0);
        chk("post_rst_aw_stall", 32'(aw_stall_o), 32'd0);
        chk("post_rst_unexp", 32'(unexp_b_o), 32'd0);
        fin();

        // In-order forwarding and unexpected B, from the vector table
        for (int i = 0; i < 11; i++) begin
            aw_hs_i = tbl[i].aw; s_bvalid_i = tbl[i].sv; s_bid_i = tbl[i].bid;
            s_bresp_i = tbl[i].bresp; m_bready_i = tbl[i].mr;
            neg();
            chk($sformatf("tbl%0d_s_bready", i), 32'(s_bready_o), 32'(tbl[i].e_bready));
            chk($sformatf("tbl%0d_m_bvalid", i), 32'(m_bvalid_o), 32'(tbl[i].e_bvalid));
            if (tbl[i].e_bvalid) begin
                chk($sformatf("tbl%0d_m_bid", i), 32'(m_bid_o), 32'(tbl[i].e_bid));
                chk($sformatf("tbl%0d_m_bresp", i), 32'(m_bresp_o), 32'(tbl[i].e_bresp));
            end
            chk($sformatf("tbl%0d_outstanding", i), 32'(outstanding_o), 32'(tbl[i].e_out));
            chk($sformatf("tbl%0d_aw_stall", i), 32'(aw_stall_o), 32'd0);
            chk($sformatf("tbl%0d_unexp", i), 32'(unexp_b_o), 32'(tbl[i].e_unexp));
            fin();
        end
        idle_inputs();

        // FIFO full: fifth response held at the slave until a pop frees space
        do_reset(1);
        got_q.delete();
        aw_hs_i = 1'b1;
        repeat (5) cycle();
        aw_hs_i = 1'b0;
        s_bvalid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_bid_i = 8'hA0 + 8'(i); s_bresp_i = 2'(i);
            cycle();
        end
        s_bid_i = 8'hA4; s_bresp_i = 2'd0;
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("full_s_bready", 32'(s_bready_o), 32'd0);
            fin();
        end
        m_bready_i = 1'b1;
        begin
            bit acc = 1'b0;
            for (int b = 0; b < 10 && !acc; b++) begin
                neg();
                acc = s_bready_o;
                fin();
            end
            if (!acc) chk("fifth_push_timeout", 32'd0, 32'd1);
        end
        s_bvalid_i = 1'b0;
        for (int b = 0; b < 20 && got_q.size() < 5; b++) cycle();
        chk("full_delivered", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < got_q.size(); i++)
            chk($sformatf("full_order%0d", i), 32'(got_q[i]), 32'({2'(i), 8'hA0 + 8'(i)}));
        neg();
        chk("full_outstanding_end", 32'(outstanding_o), 32'd0);
        fin();
        idle_inputs();

        // Outstanding limit and stall
        do_reset(1);
        aw_hs_i = 1'b1;
        repeat (6) cycle();
        aw_hs_i = 1'b0;
        neg();
        chk("lim_stall", 32'(aw_stall_o), 32'd1);
        chk("lim_outstanding", 32'(outstanding_o), 32'd6);
        fin();
        aw_hs_i = 1'b1;
        cycle();
        s_bvalid_i = 1'b1; s_bid_i = 8'h01; aw_hs_i = 1'b0;
        cycle();
        s_bvalid_i = 1'b0; aw_hs_i = 1'b1; m_bready_i = 1'b1;
        cycle();
        aw_hs_i = 1'b0; m_bready_i = 1'b0;
        neg();
        chk("lim_hs_pop_outstanding", 32'(outstanding_o), 32'd6);
        chk("lim_hs_pop_stall", 32'(aw_stall_o), 32'd1);
        fin();
        s_bvalid_i = 1'b1; s_bid_i = 8'h02;
        cycle();
        s_bvalid_i = 1'b0; m_bready_i = 1'b1;
        cycle();
        m_bready_i = 1'b0;
        neg();
        chk("lim_release_outstanding", 32'(outstanding_o), 32'd5);
        chk("lim_release_stall", 32'(aw_stall_o), 32'd0);
        fin();
        idle_inputs();

        // Mid-operation reset discards buffered responses
        do_reset(1);
        aw_hs_i = 1'b1;
        repeat (2) cycle();
        aw_hs_i = 1'b0; s_bvalid_i = 1'b1;
        s_bid_i = 8'hC1; cycle();
        s_bid_i = 8'hC2; cycle();
        s_bvalid_i = 1'b0;
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        neg();
        chk("mid_rst_m_bvalid", 32'(m_bvalid_o), 32'd0);
        chk("mid_rst_outstanding", 32'(outstanding_o), 32'd0);
        chk("mid_rst_unexp", 32'(unexp_b_o), 32'd0);
        fin();
        got_q.delete();
        m_bready_i = 1'b1;
        repeat (5) cycle();
        chk("mid_rst_no_stale", 32'(got_q.size()), 32'd0);
        idle_inputs();

        // Random traffic against the model
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            rst_i      = ($urandom_range(0, 199) == 0);
            aw_hs_i    = ($urandom_range(0, 2) == 0);
            s_bvalid_i = $urandom_range(0, 1) != 0;
            s_bid_i    = 8'($urandom);
            s_bresp_i  = 2'($urandom);
            m_bready_i = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle_inputs();
        rst_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
